// File: rtl/vol_level_meter_pkg.sv
// Shared constants and types for the volume level meter and the volume-bar
// renderer. The renderer imports the same NUM_W and MAX_LEVEL so both sides
// agree on the level range.
package vol_level_meter_pkg;

    localparam int NUM_W        = 4;
    localparam int MAX_LEVEL    = 15;
    localparam int MIC_BASELINE = 2048;

    // Window phase: ACCUM while collecting, CLOSE on the last valid sample.
    typedef enum logic {
        ACCUM = 1'b0,
        CLOSE = 1'b1
    } win_state_e;

endpackage

// File: rtl/vol_level_meter_if.sv
// Sample stream / level output bundle between the mic front end (master)
// and the level meter (slave).
//   sample_valid  one-cycle strobe, sample is valid this cycle
//   sample        unsigned mic code, SAMPLE_W bits
//   freeze        1 = hold displayed level; windowing continues
//   num           displayed volume level 0..MAX_LEVEL
//   num_valid     one-cycle pulse when a window closes
//   peak          amplitude peak of the last closed window
interface vol_level_meter_if #(
    parameter int SAMPLE_W = 12
);
    import vol_level_meter_pkg::*;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                freeze;
    logic [NUM_W-1:0]    num;
    logic                num_valid;
    logic [SAMPLE_W-1:0] peak;

    modport master (
        output sample_valid, sample, freeze,
        input  num, num_valid, peak
    );

    modport slave (
        input  sample_valid, sample, freeze,
        output num, num_valid, peak
    );

endinterface

// File: rtl/vol_level_meter_quantize.sv
// Combinational level quantiser.
//   wpk      in   peak amplitude of the closing window
//   num_cur  in   currently displayed level
//   freeze   in   1 = keep num_cur
//   num_nxt  out  level to display after this window
// The raw level is clamped to MAX_LEVEL before being narrowed to NUM_W bits.
// A rising level jumps straight to raw; a falling level steps down by one.
module vol_quantize
    import vol_level_meter_pkg::*;
#(
    parameter int SAMPLE_W  = 12,
    parameter int LVL_SHIFT = 7
) (
    input  logic [SAMPLE_W-1:0] wpk,
    input  logic [NUM_W-1:0]    num_cur,
    input  logic                freeze,
    output logic [NUM_W-1:0]    num_nxt
);

    logic [SAMPLE_W-1:0] shifted;
    logic [NUM_W-1:0]    raw;

    always_comb begin
        shifted = wpk >> LVL_SHIFT;
        if (shifted > SAMPLE_W'(MAX_LEVEL))
            raw = NUM_W'(MAX_LEVEL);
        else
            raw = shifted[NUM_W-1:0];

        num_nxt = num_cur;
        if (!freeze) begin
            if (raw >= num_cur)
                num_nxt = raw;
            else
                num_nxt = num_cur - 1'b1;   // raw < num_cur, so num_cur >= 1
        end
    end

endmodule

// File: rtl/vol_level_meter.sv
// Microphone volume level meter.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    vol_level_meter_if.slave (sample stream in, level/peak out)
// Tracks the peak amplitude above BASELINE over WINDOW valid samples and,
// at each window close, updates peak, num and pulses num_valid.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | collecting: valid samples update run_peak and win_cnt
// CLOSE | valid sample with win_cnt == WINDOW-1: publish and restart
//
// The phase is decoded from win_cnt; there is no separate state register.
module vol_level_meter
    import vol_level_meter_pkg::*;
#(
    parameter int SAMPLE_W  = 12,
    parameter int WINDOW    = 4000,
    parameter int BASELINE  = MIC_BASELINE,
    parameter int LVL_SHIFT = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    vol_level_meter_if.slave bus
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    win_state_e          state;
    logic [CNT_W-1:0]    win_cnt,   win_cnt_d;
    logic [SAMPLE_W-1:0] run_peak,  run_peak_d;
    logic [SAMPLE_W-1:0] peak_q,    peak_d;
    logic [NUM_W-1:0]    num_q,     num_d;
    logic                num_valid_q, num_valid_d;
    logic [SAMPLE_W-1:0] amp;
    logic [SAMPLE_W-1:0] wpk;
    logic [NUM_W-1:0]    num_nxt;

    vol_quantize #(
        .SAMPLE_W  (SAMPLE_W),
        .LVL_SHIFT (LVL_SHIFT)
    ) u_quantize (
        .wpk     (wpk),
        .num_cur (num_q),
        .freeze  (bus.freeze),
        .num_nxt (num_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            run_peak    <= '0;
            peak_q      <= '0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
        end else begin
            win_cnt     <= win_cnt_d;
            run_peak    <= run_peak_d;
            peak_q      <= peak_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
        end
    end

    always_comb begin
        // Below-baseline samples contribute zero amplitude, never a wrapped value.
        amp = '0;
        if (bus.sample >= SAMPLE_W'(BASELINE))
            amp = bus.sample - SAMPLE_W'(BASELINE);

        wpk = (amp > run_peak) ? amp : run_peak;

        state = ACCUM;
        if (bus.sample_valid && (win_cnt == CNT_W'(WINDOW - 1)))
            state = CLOSE;

        win_cnt_d   = win_cnt;
        run_peak_d  = run_peak;
        peak_d      = peak_q;
        num_d       = num_q;
        num_valid_d = 1'b0;

        if (bus.sample_valid) begin
            case (state)
                CLOSE: begin
                    peak_d      = wpk;
                    run_peak_d  = '0;
                    win_cnt_d   = '0;
                    num_valid_d = 1'b1;
                    num_d       = num_nxt;
                end
                default: begin
                    run_peak_d = wpk;
                    win_cnt_d  = win_cnt + 1'b1;
                end
            endcase
        end
    end

    assign bus.num       = num_q;
    assign bus.num_valid = num_valid_q;
    assign bus.peak      = peak_q;

endmodule

// File: tb/tb_vol_level_meter.sv
module tb_vol_level_meter;
    import vol_level_meter_pkg::*;

    typedef struct {
        int num;
        int peak;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulses;
    exp_t sb_q[$];

    vol_level_meter_if #(.SAMPLE_W(12)) bus ();

    vol_level_meter #(
        .SAMPLE_W  (12),
        .WINDOW    (4),
        .BASELINE  (2048),
        .LVL_SHIFT (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every num_valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.num_valid) begin
            pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_num_valid: got pulse, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("num", int'(bus.num), e.num);
                chk("peak", int'(bus.peak), e.peak);
            end
        end
    end

    // Called at a negedge; returns at a negedge after the sample was captured.
    task automatic send(input int s, input int gap);
        bus.sample_valid = 1'b1;
        bus.sample       = 12'(s);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_window(input int s0, input int s1, input int s2, input int s3,
                              input int gap, input int exp_peak, input int exp_num);
        exp_t e;
        e.num  = exp_num;
        e.peak = exp_peak;
        sb_q.push_back(e);
        send(s0, gap);
        send(s1, gap);
        send(s2, gap);
        send(s3, gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sample_valid = ~bus.sample_valid;
            bus.sample       = 12'd4095;
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        chk("rst_num", int'(bus.num), 0);
        chk("rst_peak", int'(bus.peak), 0);
        chk("rst_num_valid", int'(bus.num_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_seq(input int gap);
        run_window(2048, 2500, 2100, 2048, gap, 452, 3);
        run_window(3000, 2048, 2048, 2049, gap, 952, 7);
        run_window(2048, 2048, 2048, 2048, gap, 0,   6);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        pulses           = 0;
        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.freeze       = 1'b0;
        @(negedge clk);

        // Reset with strobes toggling
        do_reset();

        // Attack, with exact one-cycle num_valid timing
        run_window(2048, 2100, 3000, 2048, 0, 952, 7);
        chk("lat_pulse_on", int'(bus.num_valid), 1);
        @(negedge clk);
        chk("lat_pulse_off", int'(bus.num_valid), 0);

        // Mid-window asynchronous reset discards the partial window
        send(4095, 0);
        send(4095, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_num", int'(bus.num), 0);
        chk("midrst_peak", int'(bus.peak), 0);
        chk("midrst_num_valid", int'(bus.num_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_window(2048, 2048, 2048, 2048, 0, 0, 0);

        // Clamp and below-baseline
        run_window(4095, 0, 0, 0, 0, 2047, 15);
        run_window(1000, 1000, 1000, 1000, 0, 0, 14);

        // Decay from 15, then a loud window that is below the current level
        run_window(4095, 2048, 2048, 2048, 0, 2047, 15);
        for (int k = 0; k < 5; k++)
            run_window(2048, 2048, 2048, 2048, 0, 0, 14 - k);
        run_window(3100, 2048, 2048, 2048, 0, 1052, 9);
        run_window(2048, 2048, 2048, 2048, 0, 0, 8);

        // Freeze: toggled mid-window, only its value at the close matters
        bus.freeze = 1'b0;
        send(2048, 0);
        bus.freeze = 1'b1;
        sb_q.push_back('{8, 0});
        send(2048, 0);
        send(2048, 0);
        send(2048, 0);
        bus.freeze = 1'b0;
        run_window(2048, 2048, 2048, 2048, 0, 0, 7);
        repeat (2) @(negedge clk);

        // Gapped vs back-to-back strobes with identical data
        do_reset();
        pulses = 0;
        run_seq(2);
        chk("gapped_pulses", pulses, 3);
        do_reset();
        pulses = 0;
        run_seq(0);
        chk("b2b_pulses", pulses, 3);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
